// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Diff, Borrow
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Diff, Borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B over WIDTH cycles,
// LSB first, one full-subtractor cell plus a borrow flop.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bw_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             shift_en;
  logic             last;
  logic             d_bit;
  logic             bo_bit;

  // Full-subtractor cell on the current operand LSBs and the borrow flop.
  always_comb begin
    d_bit  = a_q[0] ^ b_q[0] ^ bw_q;
    bo_bit = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == LAST_BIT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake flags derived from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  // Operand shift registers, borrow flop, bit counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      res_q <= '0;
      bw_q  <= 1'b0;
      cnt_q <= '0;
    end else if (shift_en) begin
      a_q   <= {1'b0, a_q[WIDTH-1:1]};
      b_q   <= {1'b0, b_q[WIDTH-1:1]};
      res_q <= {d_bit, res_q[WIDTH-1:1]};
      bw_q  <= bo_bit;
      if (last) begin
        diff_q   <= {d_bit, res_q[WIDTH-1:1]};
        borrow_q <= bo_bit;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Diff      = diff_q;
  assign bus.Borrow    = borrow_q;

endmodule
